// File: rtl/doodlejump_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : doodlejump_multi_timer
// Brief    : NUM_CH-channel Avalon-MM interval timer with a shared OR'd irq.
//            Optional shared tick prescaler: DOODLEJUMP_MULTI_TIMER_PRESCALER_EN
// Revision : 1.0
// ============================================================================
module doodlejump_multi_timer #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 49999,
    parameter int ADDR_W       = $clog2(NUM_CH) + 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              chipselect_i,
    input  logic              write_n_i,
    input  logic [31:0]       writedata_i,
    output logic [31:0]       readdata_o,
    output logic              irq_o
);

    localparam int               BLK_W   = ADDR_W - 2;
    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_PERIOD);

    logic              w_wr;
    logic              w_rd;
    logic [BLK_W-1:0]  w_blk;
    logic              w_glb_sel;
    logic              w_tick;
    logic [15:0]       w_presc_rd;
    logic [NUM_CH-1:0] w_to;
    logic [NUM_CH-1:0] w_ito;
    logic [NUM_CH-1:0] w_clr_pend;
    logic [31:0]       w_ch_rdata [NUM_CH];
    logic [31:0]       w_rdata;
    logic [31:0]       readdata_q;

    assign w_wr      = chipselect_i & ~write_n_i;
    assign w_rd      = chipselect_i & write_n_i;
    assign w_blk     = address_i[ADDR_W-1:2];
    assign w_glb_sel = (w_blk == BLK_W'(NUM_CH));
    assign w_clr_pend = (w_wr && w_glb_sel && address_i[1:0] == 2'd0)
                        ? writedata_i[NUM_CH-1:0] : '0;

`ifdef DOODLEJUMP_MULTI_TIMER_PRESCALER_EN
    logic [15:0] presc_q, presc_d;
    logic [15:0] div_q, div_d;
    logic        w_wr_presc;

    assign w_wr_presc = w_wr && w_glb_sel && (address_i[1:0] == 2'd1);
    assign w_tick     = (div_q == presc_q);
    assign w_presc_rd = presc_q;

    always_comb begin
        presc_d = presc_q;
        div_d   = w_tick ? 16'd0 : div_q + 16'd1;
        if (w_wr_presc) begin
            presc_d = writedata_i[15:0];
            div_d   = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= 16'd0;
            div_q   <= 16'd0;
        end else begin
            presc_q <= presc_d;
            div_q   <= div_d;
        end
    end
`else
    assign w_tick     = 1'b1;
    assign w_presc_rd = 16'd0;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] period_q, period_d;
        logic [CNT_W-1:0] snap_q, snap_d;
        logic             to_q, to_d;
        logic             run_q, run_d;
        logic             ito_q, ito_d;
        logic             cont_q, cont_d;
        logic             zero_q;
        logic             w_sel;
        logic             w_is_zero;
        logic             w_event;
        logic [31:0]      w_rd_ch;

        assign w_sel     = (w_blk == BLK_W'(c));
        assign w_is_zero = (cnt_q == '0);
        assign w_event   = w_is_zero & ~zero_q;

        // Later assignments take priority: writes over counting, TO set over clears.
        always_comb begin
            cnt_d    = cnt_q;
            period_d = period_q;
            snap_d   = snap_q;
            to_d     = to_q;
            run_d    = run_q;
            ito_d    = ito_q;
            cont_d   = cont_q;
            if (run_q && w_tick) begin
                if (!w_is_zero)
                    cnt_d = cnt_q - 1'b1;
                else if (cont_q || !w_event)
                    cnt_d = period_q;
            end
            if (w_event && !cont_q)
                run_d = 1'b0;
            if (w_wr && w_sel) begin
                case (address_i[1:0])
                    2'd0: to_d = 1'b0;
                    2'd1: begin
                        ito_d  = writedata_i[0];
                        cont_d = writedata_i[1];
                        if (writedata_i[3]) run_d = 1'b0;
                        if (writedata_i[2]) run_d = 1'b1;
                    end
                    2'd2: begin
                        period_d = writedata_i[CNT_W-1:0];
                        cnt_d    = writedata_i[CNT_W-1:0];
                        run_d    = 1'b0;
                    end
                    default: snap_d = cnt_q;
                endcase
            end
            if (w_clr_pend[c])
                to_d = 1'b0;
            if (w_event)
                to_d = 1'b1;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q    <= RST_CNT;
                period_q <= RST_CNT;
                snap_q   <= '0;
                to_q     <= 1'b0;
                run_q    <= 1'b0;
                ito_q    <= 1'b0;
                cont_q   <= 1'b0;
                zero_q   <= 1'b1;
            end else begin
                cnt_q    <= cnt_d;
                period_q <= period_d;
                snap_q   <= snap_d;
                to_q     <= to_d;
                run_q    <= run_d;
                ito_q    <= ito_d;
                cont_q   <= cont_d;
                zero_q   <= w_is_zero;
            end
        end

        always_comb begin
            w_rd_ch = '0;
            if (w_sel) begin
                case (address_i[1:0])
                    2'd0:    w_rd_ch = {30'd0, run_q, to_q};
                    2'd1:    w_rd_ch = {30'd0, cont_q, ito_q};
                    2'd2:    w_rd_ch = 32'(period_q);
                    default: w_rd_ch = 32'(snap_q);
                endcase
            end
        end

        assign w_ch_rdata[c] = w_rd_ch;
        assign w_to[c]       = to_q;
        assign w_ito[c]      = ito_q;
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_CH; i++)
            w_rdata = w_rdata | w_ch_rdata[i];
        if (w_glb_sel) begin
            case (address_i[1:0])
                2'd0:    w_rdata = 32'(w_to);
                2'd1:    w_rdata = {16'd0, w_presc_rd};
                default: w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata_q <= '0;
        else if (w_rd)
            readdata_q <= w_rdata;
    end

    assign readdata_o = readdata_q;
    assign irq_o      = |(w_to & w_ito);

endmodule
`default_nettype wire

// File: doc/doodlejump_multi_timer.md
# doodlejump_multi_timer

Parametrised multi-channel interval timer on the Avalon-MM bus of the doodlejump SoC, successor to the single fixed 16-bit-data interval timer. NUM_CH independent down-counters of CNT_W bits, each with period, snapshot, one-shot/continuous mode and an interrupt enable. One OR-combined irq line plus a global pending mask lets the Nios ISR find the source in a single read. Serves game tick, animation and input-debounce timing from one peripheral.

## Interface
- NUM_CH, 4, number of channels, 1..8
- CNT_W, 32, counter/period width, 8..32
- RESET_PERIOD, 49999, reset value of every PERIOD register and counter (truncated to CNT_W)
- ADDR_W, $clog2(NUM_CH)+3, derived word-address width; not overridden
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  ADDR_W  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  OR of all enabled pending timeouts

## Operation
- Channel c register map, base c*4:
  - +0 STATUS: bit0 TO (pending), bit1 RUN. Any write clears TO.
  - +1 CONTROL: bit0 ITO, bit1 CONT. Writing bit2 START or bit3 STOP strobes; bits 2,3 are not stored and read 0.
  - +2 PERIOD: CNT_W bits; upper bits read 0.
  - +3 SNAPSHOT: any write copies the live counter; a read returns the copy.
- Global registers at NUM_CH*4:
  - +0 PENDING: bit c = TO of channel c. Writing a 1 clears that TO.
  - +1 PRESCALE: only with the macro in Configuration.
- Unmapped addresses read 0. Writes to them are ignored.
- Counter runs while RUN and a tick is present (tick = every cycle without the macro):
  - at nonzero value: decrement by 1;
  - at 0: reload PERIOD, giving PERIOD+1 ticks per timeout.
- Timeout event: counter reaches 0 (rising edge of is_zero). Sets TO.
  - One-shot (CONT=0): RUN also clears; the counter holds at 0.
- PERIOD write: the cycle after, the counter loads the new PERIOD and RUN clears (force reload). START is required to resume.
- START and STOP in the same write: START wins.
- TO set and TO clear (STATUS or PENDING write) in the same cycle: the set wins, so no event is lost.
- START on a stopped counter at 0:
  - one-shot: reloads on the next tick, then counts down;
  - continuous: same.
- irq = |(TO[c] & ITO[c]), combinational from registers.
- Reset values:
  - counters and PERIOD = RESET_PERIOD;
  - TO, RUN, CONTROL, SNAPSHOT = 0;
  - readdata = 0; irq = 0;
  - prescaler = 0.

## Timing
- Read latency 1 cycle: readdata updates on the clk edge following the address. No wait states.
- Writes take effect on the clk edge where chipselect & ~write_n.
- START written at edge N: RUN=1 after N; first decrement at edge N+1.
- Counter reaches 0 at edge N: TO=1 after edge N+1; irq high the same cycle if ITO=1.
- Reset assertion mid-count returns every register to its reset value immediately (asynchronous); counting resumes only after START.

## Configuration
- DOODLEJUMP_MULTI_TIMER_PRESCALER_EN defined:
  - 16-bit PRESCALE register (reset 0) at global +1;
  - a free-running divider produces one tick every PRESCALE+1 clk cycles, shared by all channels;
  - a PRESCALE write restarts the divider;
  - PRESCALE=0 behaves exactly as the undefined case.
- Macro undefined: no PRESCALE register, tick every cycle, global +1 reads 0.

## Test plan
- Reset, then read ch0 PERIOD -> 49999 (0xC34F); STATUS=0; irq=0.
- ch1: PERIOD=9, CONTROL=ITO|CONT|START -> TO set every 10 cycles; irq high until a STATUS write; PENDING reads 0x2.
- ch2 one-shot: PERIOD=3, START -> single timeout, then RUN=0 and the counter holds at 0; a second START gives one more timeout 4 ticks later.
- Run ch0 at PERIOD=100; write PERIOD=5 mid-count -> RUN=0, counter=5 next cycle; after START, timeout 6 cycles later.
- Clear TO via PENDING in the exact cycle of a new timeout -> TO remains 1. SNAPSHOT write at counter value 0x20 -> the read returns 0x20.
- With the macro, PRESCALE=3, PERIOD=1 -> timeout every 8 clk cycles. Assert reset_n mid-count -> all outputs 0 and PERIOD back to 49999.
